// File: rtl/spfp_accumulate_ctrl_pkg.sv
// Shared encodings and constants for the single-precision accumulate controller
// and its adder.
package spfp_accumulate_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } acc_state_e;

    localparam logic [31:0] FP_ZERO      = 32'h0000_0000;
    localparam logic [7:0]  EXP_ALL_ONES = 8'hFF;

    // Inf and NaN both count as exceptional operands.
    function automatic logic is_special(input logic [31:0] x);
        return x[30:23] == EXP_ALL_ONES;
    endfunction

endpackage

// File: rtl/spfp_adder_subtractor.sv
// Combinational IEEE-754 single add/subtract, round-to-nearest-even, subnormals
// flushed to zero. Any Inf/NaN operand or overflow raises exception_o and forces +0.
module spfp_adder_subtractor
    import spfp_accumulate_ctrl_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        add_sub_signal_i,
    output logic [31:0] res_o,
    output logic        exception_o
);

    logic        sign_b, big_s, sm_s;
    logic [7:0]  big_e, sm_e, d;
    logic [22:0] big_f, sm_f;
    logic [26:0] big_m, sm_m, sm_sh, mask, diff, norm;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [9:0]  e;
    logic [23:0] mant;
    logic [24:0] mant_r;
    logic        found, rnd, zero, ovf, uf, exc;

    always_comb begin
        sign_b = b_i[31] ^ ~add_sub_signal_i;
        exc    = is_special(a_i) | is_special(b_i);

        // Larger magnitude goes on the "big" side so the aligned difference is never negative.
        if (a_i[30:0] >= b_i[30:0]) begin
            big_s = a_i[31];  big_e = a_i[30:23]; big_f = a_i[22:0];
            sm_s  = sign_b;   sm_e  = b_i[30:23]; sm_f  = b_i[22:0];
        end else begin
            big_s = sign_b;   big_e = b_i[30:23]; big_f = b_i[22:0];
            sm_s  = a_i[31];  sm_e  = a_i[30:23]; sm_f  = a_i[22:0];
        end

        big_m = (big_e != 8'd0) ? {1'b1, big_f, 3'b000} : '0;
        sm_m  = (sm_e  != 8'd0) ? {1'b1, sm_f,  3'b000} : '0;

        d    = big_e - sm_e;
        mask = '0;
        if (d >= 8'd27) begin
            sm_sh = {26'd0, |sm_m};
        end else begin
            mask     = (27'd1 << d) - 27'd1;
            sm_sh    = sm_m >> d;
            sm_sh[0] = sm_sh[0] | (|(sm_m & mask));
        end

        sum   = '0;
        diff  = '0;
        norm  = '0;
        lz    = '0;
        found = 1'b0;
        zero  = 1'b0;
        e     = {2'b00, big_e};
        if (big_s == sm_s) begin
            sum = {1'b0, big_m} + {1'b0, sm_sh};
            if (sum[27]) begin
                norm = {sum[27:2], sum[1] | sum[0]};
                e    = e + 10'd1;
            end else begin
                norm = sum[26:0];
            end
        end else begin
            diff = big_m - sm_sh;
            for (int i = 26; i >= 0; i--) begin
                if (!found && diff[i]) begin
                    lz    = 5'(26 - i);
                    found = 1'b1;
                end
            end
            norm = diff << lz;
            e    = e - {5'd0, lz};
            zero = (diff == '0);
        end

        mant   = norm[26:3];
        rnd    = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant_r = {1'b0, mant} + {24'd0, rnd};
        if (mant_r[24]) begin
            mant = mant_r[24:1];
            e    = e + 10'd1;
        end else begin
            mant = mant_r[23:0];
        end

        ovf = !e[9] && (e >= 10'd255);
        uf  = e[9] || (e == 10'd0) || !mant[23];

        exception_o = exc | ovf;
        res_o       = {big_s, e[7:0], mant[22:0]};
        if (exc || ovf || uf || zero)
            res_o = FP_ZERO;
    end

endmodule

// File: rtl/spfp_accumulate_ctrl.sv
// Reduces a vector of singles to one biased sum, one add per accepted beat,
// and returns the sum plus a sticky Inf/NaN flag on a valid/ready port.
module spfp_accumulate_ctrl
    import spfp_accumulate_ctrl_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [LEN_W-1:0] vec_len_i,
    input  logic [31:0]      bias_i,
    input  logic             abort_i,
    input  logic             in_valid_i,
    input  logic [31:0]      in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      out_data_o,
    output logic             out_exception_o,
    output logic             busy_o
);

    acc_state_e       state_q, state_d;
    logic [31:0]      acc_q, acc_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic             exc_q, exc_d;
    logic [31:0]      add_res;
    logic             add_exc;

    spfp_adder_subtractor u_add (
        .a_i              (acc_q),
        .b_i              (in_data_i),
        .add_sub_signal_i (1'b1),
        .res_o            (add_res),
        .exception_o      (add_exc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= FP_ZERO;
            count_q <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            exc_q   <= exc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        exc_d   = exc_q;

        // Abort wins over everything, including a beat presented in the same cycle.
        if (abort_i) begin
            state_d = ST_IDLE;
            acc_d   = FP_ZERO;
            count_d = '0;
            exc_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        acc_d = bias_i;
                        exc_d = is_special(bias_i);
                        if (vec_len_i != '0) begin
                            count_d = vec_len_i;
                            state_d = ST_ACC;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_ACC: begin
                    if (in_valid_i) begin
                        acc_d   = add_res;
                        exc_d   = exc_q | add_exc;
                        count_d = count_q - LEN_W'(1);
                        if (count_q == LEN_W'(1))
                            state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready_i)
                        state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Handshake outputs decode from state only; no in_valid -> in_ready path.
    assign in_ready_o      = (state_q == ST_ACC);
    assign out_valid_o     = (state_q == ST_DONE);
    assign busy_o          = (state_q != ST_IDLE);
    assign out_data_o      = acc_q;
    assign out_exception_o = exc_q;

endmodule

// File: tb/tb_spfp_accumulate_ctrl.sv
// Scoreboard bench: stimulus pushes expected sums computed in exact half-unit
// integer arithmetic; a negedge monitor compares whenever out_valid is high.
module tb_spfp_accumulate_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [7:0]  vec_len_i;
    logic [31:0] bias_i;
    logic        abort_i;
    logic        in_valid_i;
    logic [31:0] in_data_i;
    logic        in_ready_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_data_o;
    logic        out_exception_o;
    logic        busy_o;

    typedef struct {
        logic [31:0] data;
        logic        exc;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int errors = 0;

    spfp_accumulate_ctrl #(.LEN_W(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start_i),
        .vec_len_i       (vec_len_i),
        .bias_i          (bias_i),
        .abort_i         (abort_i),
        .in_valid_i      (in_valid_i),
        .in_data_i       (in_data_i),
        .in_ready_o      (in_ready_o),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .out_data_o      (out_data_o),
        .out_exception_o (out_exception_o),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Exact single-precision encoding of h/2 (|h| < 2^24).
    function automatic logic [31:0] fp_of_halves(input int h);
        int          mag;
        int          p;
        logic [31:0] m32;
        if (h == 0) return 32'h0;
        mag = (h < 0) ? -h : h;
        p = 0;
        for (int i = 0; i < 31; i++) if (mag[i]) p = i;
        m32 = 32'(mag) << (23 - p);
        return {(h < 0), 8'(126 + p), m32[22:0]};
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid_o) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out got=%h expected=none", out_data_o);
            end else begin
                chk("out_data", out_data_o, sb_q[0].data);
                chk("out_exc", 32'(out_exception_o), 32'(sb_q[0].exc));
                if (out_ready_i) void'(sb_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One full reduction: start, feed beats with random bubbles, then hold DONE.
    task automatic run(input logic [31:0] bias, input int len, input logic [31:0] el[$],
                       input int bub, input int hold, input exp_t e, output int lat);
        int idx = 0;
        logic hs;
        sb_q.push_back(e);
        start_i = 1'b1; vec_len_i = 8'(len); bias_i = bias; in_valid_i = 1'b0;
        cyc();
        start_i = 1'b0;
        lat = 1;
        while (!out_valid_o) begin
            if (lat > 2000) begin
                $display("FAIL run_timeout got=%0d expected=done", lat);
                $fatal(1, "timeout");
            end
            chk("in_ready_acc", 32'(in_ready_o), 32'd1);
            in_valid_i = (idx < len) && (int'($urandom_range(99)) >= bub);
            in_data_i  = (idx < len) ? el[idx] : 32'h0;
            hs = in_valid_i;
            cyc();
            lat++;
            if (hs) idx++;
        end
        in_valid_i = 1'b0;
        for (int k = 0; k <= hold; k++) begin
            start_i     = 1'b1;
            vec_len_i   = 8'($urandom_range(1, 5));
            out_ready_i = (k == hold);
            chk("in_ready_done", 32'(in_ready_o), 32'd0);
            cyc();
        end
        start_i = 1'b0; out_ready_i = 1'b0;
        chk("busy_after_out", 32'(busy_o), 32'd0);
        chk("valid_after_out", 32'(out_valid_o), 32'd0);
    endtask

    task automatic rand_run(input int maxlen, input int range);
        int          len, bias_h, acc_h;
        logic        bias_sp, acc_sp, exc;
        logic [31:0] bias, acc_bits;
        logic [31:0] el[$];
        int          lat;
        exp_t        e;
        logic [31:0] specials[4] = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h7F80_0001};
        len = $urandom_range(0, maxlen);
        bias_sp = ($urandom_range(19) == 0);
        bias_h = int'($urandom_range(2 * range)) - range;
        bias = bias_sp ? specials[$urandom_range(3)] : fp_of_halves(bias_h);
        acc_sp = bias_sp; acc_bits = bias; acc_h = bias_h; exc = bias_sp;
        for (int i = 0; i < len; i++) begin
            int h = int'($urandom_range(2 * range)) - range;
            logic sp = ($urandom_range(11) == 0);
            el.push_back(sp ? specials[$urandom_range(3)] : fp_of_halves(h));
            if (sp || acc_sp) begin
                acc_sp = 1'b0; acc_h = 0; exc = 1'b1;
            end else begin
                acc_h += h;
            end
        end
        e.data = acc_sp ? acc_bits : fp_of_halves(acc_h);
        e.exc  = exc;
        run(bias, len, el, 30, $urandom_range(0, 3), e, lat);
    endtask

    initial begin
        int          lat;
        logic [31:0] el[$];
        exp_t        e;

        rst_n = 1'b0; start_i = 1'b0; vec_len_i = '0; bias_i = '0; abort_i = 1'b0;
        in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
        #12;
        chk("rst_out_data", out_data_o, 32'h0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_in_ready", 32'(in_ready_o), 32'd0);
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_out_exc", 32'(out_exception_o), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        cyc();

        // Basic back-to-back reduction: 0.5 + 1 + 2 + 3
        el = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
        e.data = 32'h40D0_0000; e.exc = 1'b0;
        run(32'h3F00_0000, 3, el, 0, 0, e, lat);
        chk("lat_basic", 32'(lat), 32'd4);

        // Negative element after bubbles: 3.0 + -1.0
        el = '{32'hBF80_0000};
        e.data = 32'h4000_0000; e.exc = 1'b0;
        run(32'h4040_0000, 1, el, 70, 1, e, lat);

        // Zero length returns bias after one cycle
        el = '{};
        e.data = 32'h4080_0000; e.exc = 1'b0;
        run(32'h4080_0000, 0, el, 0, 0, e, lat);
        chk("lat_zero_len", 32'(lat), 32'd1);

        // Inf element zeroes the sum, later beats keep accumulating
        el = '{32'h7F80_0000, 32'h3F80_0000};
        e.data = 32'h3F80_0000; e.exc = 1'b1;
        run(32'h3F80_0000, 2, el, 0, 0, e, lat);

        // Long DONE backpressure with start held high
        el = '{32'h4000_0000, 32'h4000_0000};
        e.data = 32'h40A0_0000; e.exc = 1'b0;
        run(32'h3F80_0000, 2, el, 0, 5, e, lat);

        // Abort after one of three beats; the coincident beat is dropped
        start_i = 1'b1; vec_len_i = 8'd3; bias_i = 32'h3F80_0000;
        cyc();
        start_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'h4000_0000;
        cyc();
        in_data_i = 32'h4040_0000; abort_i = 1'b1;
        cyc();
        abort_i = 1'b0; in_valid_i = 1'b0;
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_in_ready", 32'(in_ready_o), 32'd0);
        chk("abort_out_valid", 32'(out_valid_o), 32'd0);
        cyc();
        chk("abort_idle_hold", 32'(busy_o), 32'd0);
        el = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
        e.data = 32'h40D0_0000; e.exc = 1'b0;
        run(32'h3F00_0000, 3, el, 20, 1, e, lat);

        // Asynchronous reset in the middle of ACC with a nonzero running sum
        start_i = 1'b1; vec_len_i = 8'd3; bias_i = 32'h4000_0000;
        cyc();
        start_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'h3F80_0000;
        cyc();
        in_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_data", out_data_o, 32'h0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_in_ready", 32'(in_ready_o), 32'd0);
        chk("arst_out_valid", 32'(out_valid_o), 32'd0);
        chk("arst_out_exc", 32'(out_exception_o), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        in_valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("post_rst_idle", 32'(busy_o), 32'd0);
        end
        in_valid_i = 1'b0;

        // Randomised reductions, plus one maximum-length vector
        for (int t = 0; t < 30; t++) rand_run(8, 2000);
        begin
            int          acc_h = 0;
            logic [31:0] lel[$];
            for (int i = 0; i < 255; i++) begin
                int h = int'($urandom_range(40)) - 20;
                lel.push_back(fp_of_halves(h));
                acc_h += h;
            end
            e.data = fp_of_halves(6 + acc_h); e.exc = 1'b0;
            run(32'h4040_0000, 255, lel, 10, 2, e, lat);
        end

        repeat (3) cyc();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spfp_accumulate_ctrl.md
Name: spfp_accumulate_ctrl

Overview:
Sequencing controller that reduces a vector of single-precision floats to one sum, seeded with a bias, for a neuron's dot-product tail. It owns one instance of the shared combinational adder/subtractor, driven in addition mode. It performs one accumulation per accepted input beat, registers the running sum, and presents the final sum on a valid/ready output port. A sticky flag records any exponent-255 operand.

Parameters:
LEN_W, 8, width of the vector-length field; maximum vector length is 2^LEN_W-1.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
start  input  1  begin a reduction; sampled only in IDLE
vec_len  input  LEN_W  number of input elements; sampled with start
bias  input  32  IEEE-754 single seed value; sampled with start
abort  input  1  synchronous cancel; returns to IDLE from any state
in_valid  input  1  input element valid
in_data  input  32  IEEE-754 single input element
in_ready  output  1  controller accepts in_data this cycle
out_valid  output  1  final sum available
out_ready  input  1  consumer accepts the result
out_data  output  32  final sum
out_exception  output  1  sticky exception for this reduction; valid with out_valid
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; acc=0; count=0; exc=0; in_ready=0; out_valid=0; out_data=0; out_exception=0; busy=0.
- Datapath: adder operands are a=acc and b=in_data; add_sub_signal tied to 1 (addition). The adder result and exception bit are registered only on an input handshake (in_valid & in_ready).
- State IDLE: in_ready=0, out_valid=0.
  - start & vec_len!=0: acc<=bias; count<=vec_len; exc<=&bias[30:23]; go to ACC.
  - start & vec_len==0: acc<=bias; exc<=&bias[30:23]; go to DONE.
- State ACC: in_ready=1 combinationally.
  - On handshake: acc<=adder res; exc<=exc|adder exception; count<=count-1.
  - Handshake with count==1: go to DONE on the next edge.
  - No handshake: hold all state. Bubbles are allowed without limit.
- State DONE: out_valid=1; out_data=acc; out_exception=exc; in_ready=0.
  - out_ready high: go to IDLE on that edge.
  - out_data and out_exception stay stable while out_valid=1 and out_ready=0.
- Exception propagation: when the adder flags an exception its result is 0, so acc becomes 0. Later elements keep accumulating from 0. exc stays set until the next start.
- Latency: N elements with no bubbles give out_valid at the cycle after the Nth handshake. start to out_valid is N+1 cycles; vec_len==0 gives 1 cycle.
- start while not IDLE: ignored. start and out_ready in the same DONE cycle: the start is ignored.
- abort has priority over every other event.
  - From any state: go to IDLE; acc, count and exc cleared.
  - No handshake completes in the abort cycle.
  - If abort and a handshake coincide in ACC, the beat is dropped.
- count is LEN_W bits and never wraps. Reaching ACC requires count>=1, and the exit is taken at count==1.
- out_data and out_exception are registers; out_valid and in_ready decode from the state register. There is no combinational path from in_valid to in_ready.

Decomposition:
- Shared include file holds:
  - FSM state encodings: IDLE=2'd0, ACC=2'd1, DONE=2'd2.
  - FP_ZERO=32'h0000_0000.
  - EXP_ALL_ONES=8'hFF.
- One natural sub-module: the existing spfp_adder_subtractor, instantiated once. The FSM and counter stay in this module.

Test Plan:
- Basic reduction: bias=0x3F000000 (0.5), vec_len=3, in_data 0x3F800000, 0x40000000, 0x40400000 back-to-back -> out_data=0x40D00000 (6.5), out_exception=0, out_valid 4 cycles after start.
- Signed input with bubbles: bias=0x40400000 (3.0), vec_len=1, in_data=0xBF800000 (-1.0) with in_valid low for 3 cycles first -> out_data=0x40000000 (2.0), in_ready high throughout ACC.
- Zero length: start with vec_len=0, bias=0x40800000 -> out_valid the next cycle, out_data=0x40800000, no in_ready pulse.
- Exception: vec_len=2, bias=0x3F800000, in_data 0x7F800000 then 0x3F800000 -> out_exception=1, out_data=0x3F800000 (0 then +1.0).
- Backpressure and abort:
  - Hold out_ready=0 for 5 cycles in DONE -> out_data stable, start ignored.
  - Separately, assert abort after 1 of 3 beats -> IDLE next cycle, busy=0; a new run gives a correct sum.
- Reset mid-ACC: drop rst_n asynchronously -> all outputs 0 immediately. After release the block sits in IDLE until start.
